// File: rtl/dmem_pkg.sv
// Shared definitions for the handshaked data memory: size codes, FSM states, index width helper.
package dmem_pkg;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;
   localparam logic [1:0] SZ_ILL  = 2'b11;

   typedef enum logic [1:0] {
      INIT = 2'd0,
      IDLE = 2'd1,
      BUSY = 2'd2
   } state_t;

   function automatic int unsigned index_w(input int unsigned depth);
      return $clog2(depth);
   endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering: store lane mask and replicated write data, load lane shift with sign/zero extension.
module dmem_lane_align
   import dmem_pkg::*;
(
   input  logic [1:0]  i_st_size,
   input  logic [1:0]  i_st_off,
   input  logic [31:0] i_st_wdata,
   output logic [3:0]  o_st_be,
   output logic [31:0] o_st_wdata,
   input  logic [1:0]  i_ld_size,
   input  logic [1:0]  i_ld_off,
   input  logic        i_ld_unsigned,
   input  logic [31:0] i_ld_word,
   output logic [31:0] o_ld_data
);

   logic [31:0] w_ld_shift;

   // Write data is replicated across lanes so the byte enables alone pick the target lane.
   always_comb begin
      o_st_be    = '0;
      o_st_wdata = i_st_wdata;
      case (i_st_size)
         SZ_BYTE: begin
            o_st_be    = 4'b0001 << i_st_off;
            o_st_wdata = {4{i_st_wdata[7:0]}};
         end
         SZ_HALF: begin
            o_st_be    = i_st_off[1] ? 4'b1100 : 4'b0011;
            o_st_wdata = {2{i_st_wdata[15:0]}};
         end
         SZ_WORD: o_st_be = 4'b1111;
         default: o_st_be = '0;
      endcase
   end

   assign w_ld_shift = i_ld_word >> {i_ld_off, 3'b000};

   always_comb begin
      o_ld_data = '0;
      case (i_ld_size)
         SZ_BYTE: o_ld_data = i_ld_unsigned ? {24'd0, w_ld_shift[7:0]}
                                            : {{24{w_ld_shift[7]}}, w_ld_shift[7:0]};
         SZ_HALF: o_ld_data = i_ld_unsigned ? {16'd0, w_ld_shift[15:0]}
                                            : {{16{w_ld_shift[15]}}, w_ld_shift[15:0]};
         SZ_WORD: o_ld_data = i_ld_word;
         default: o_ld_data = '0;
      endcase
   end

endmodule

// File: rtl/data_memory_hs.sv
// Clocked data memory with byte/half/word access, valid/ready handshake and address error reporting.
// Optional DMEM_INIT_CLEAR_EN: clear every word after reset before accepting requests.
module data_memory_hs
   import dmem_pkg::*;
#(
   parameter int unsigned DEPTH  = 256,
   parameter int unsigned ADDR_W = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_write,
   input  logic [1:0]        req_size,
   input  logic              req_unsigned,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [31:0]       req_wdata,
   output logic              resp_valid,
   input  logic              resp_ready,
   output logic [31:0]       resp_rdata,
   output logic              resp_err
);

   localparam int unsigned IW = index_w(DEPTH);

   state_t      r_state;
   logic        r_resp_valid;
   logic        r_err;
   logic        r_ld;
   logic [1:0]  r_size;
   logic [1:0]  r_off;
   logic        r_uns;
   logic [31:0] r_rword;
   logic [31:0] r_mem [DEPTH];

   logic [IW-1:0] w_idx;
   logic          w_oob;
   logic          w_err;
   logic          w_accept;
   logic          w_store_we;
   logic [3:0]    w_be;
   logic [31:0]   w_wdata_sh;
   logic [31:0]   w_ld_data;

`ifdef DMEM_INIT_CLEAR_EN
   logic [IW-1:0] r_init_idx;
`endif

   assign w_idx = req_addr[IW+1:2];

   // DEPTH is a power of two, so any set bit above the index field means out of range.
   generate
      if (ADDR_W > IW + 2) begin : g_oob
         assign w_oob = |req_addr[ADDR_W-1:IW+2];
      end else begin : g_no_oob
         assign w_oob = 1'b0;
      end
   endgenerate

   assign w_err = (req_size == SZ_ILL)
               || ((req_size == SZ_HALF) && req_addr[0])
               || ((req_size == SZ_WORD) && (req_addr[1:0] != 2'b00))
               || w_oob;

   assign req_ready  = (r_state == IDLE) || ((r_state == BUSY) && resp_ready);
   assign w_accept   = req_valid && req_ready;
   assign w_store_we = w_accept && req_write && !w_err;

   dmem_lane_align u_align (
      .i_st_size     (req_size),
      .i_st_off      (req_addr[1:0]),
      .i_st_wdata    (req_wdata),
      .o_st_be       (w_be),
      .o_st_wdata    (w_wdata_sh),
      .i_ld_size     (r_size),
      .i_ld_off      (r_off),
      .i_ld_unsigned (r_uns),
      .i_ld_word     (r_rword),
      .o_ld_data     (w_ld_data)
   );

   // RAM array: no reset so it maps to memory; read is registered at the accept edge.
   always_ff @(posedge clk) begin
`ifdef DMEM_INIT_CLEAR_EN
      if (r_state == INIT) begin
         r_mem[r_init_idx] <= '0;
      end else
`endif
      if (w_store_we) begin
         for (int unsigned b = 0; b < 4; b++) begin
            if (w_be[b]) r_mem[w_idx][8*b +: 8] <= w_wdata_sh[8*b +: 8];
         end
      end
      if (w_accept) r_rword <= r_mem[w_idx];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
`ifdef DMEM_INIT_CLEAR_EN
         r_state    <= INIT;
         r_init_idx <= '0;
`else
         r_state    <= IDLE;
`endif
         r_resp_valid <= 1'b0;
         r_err        <= 1'b0;
         r_ld         <= 1'b0;
         r_size       <= SZ_WORD;
         r_off        <= '0;
         r_uns        <= 1'b0;
      end else begin
         case (r_state)
`ifdef DMEM_INIT_CLEAR_EN
            INIT: begin
               r_init_idx <= r_init_idx + IW'(1);
               if (r_init_idx == IW'(DEPTH - 1)) r_state <= IDLE;
            end
`endif
            IDLE:    if (w_accept) r_state <= BUSY;
            BUSY:    if (resp_ready && !req_valid) r_state <= IDLE;
            default: r_state <= IDLE;
         endcase

         // Response fields only change on an accept, which keeps them stable under backpressure.
         if (w_accept) begin
            r_resp_valid <= 1'b1;
            r_err        <= w_err;
            r_ld         <= !req_write && !w_err;
            r_size       <= req_size;
            r_off        <= req_addr[1:0];
            r_uns        <= req_unsigned;
         end else if (resp_ready) begin
            r_resp_valid <= 1'b0;
            r_err        <= 1'b0;
            r_ld         <= 1'b0;
         end
      end
   end

   assign resp_valid = r_resp_valid;
   assign resp_err   = r_err;
   assign resp_rdata = (r_resp_valid && r_ld) ? w_ld_data : '0;

endmodule

// File: tb/tb_data_memory_hs.sv
// Self-checking bench for data_memory_hs (DEPTH=16) against a byte-addressed reference model.
module tb_data_memory_hs;

   localparam int unsigned DEPTH  = 16;
   localparam int unsigned NBYTES = DEPTH * 4;
`ifdef DMEM_INIT_CLEAR_EN
   localparam int EXP_INIT = 16;
`else
   localparam int EXP_INIT = 0;
`endif

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_valid;
   logic        req_ready;
   logic        req_write;
   logic [1:0]  req_size;
   logic        req_unsigned;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic        resp_ready;
   logic [31:0] resp_rdata;
   logic        resp_err;

   int checks = 0;
   int errors = 0;

   logic [7:0] m_byte [NBYTES];

   data_memory_hs #(.DEPTH(DEPTH), .ADDR_W(32)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_write    (req_write),
      .req_size     (req_size),
      .req_unsigned (req_unsigned),
      .req_addr     (req_addr),
      .req_wdata    (req_wdata),
      .resp_valid   (resp_valid),
      .resp_ready   (resp_ready),
      .resp_rdata   (resp_rdata),
      .resp_err     (resp_err)
   );

   always #5 clk = ~clk;

   // Reference: little-endian byte memory; errors leave memory untouched and return 0.
   function automatic void model(input logic w, input logic [1:0] sz, input logic u,
                                 input logic [31:0] a, input logic [31:0] wd,
                                 output logic [31:0] rd, output logic e);
      int nb;
      logic [31:0] v;
      nb = 1 << sz;
      e  = (sz == 2'd3) || (sz == 2'd1 && a % 2 != 0) || (sz == 2'd2 && a % 4 != 0)
        || (a / 4 >= DEPTH);
      rd = '0;
      if (!e) begin
         if (w) begin
            for (int i = 0; i < nb; i++) m_byte[int'(a) + i] = wd[8*i +: 8];
         end else begin
            v = '0;
            for (int i = 0; i < nb; i++) v = v | (32'(m_byte[int'(a) + i]) << (8 * i));
            if (!u && nb < 4 && v[8*nb-1]) v = v - (32'd1 << (8 * nb));
            rd = v;
         end
      end
   endfunction

   task automatic do_req(input logic w, input logic [1:0] sz, input logic u,
                         input logic [31:0] a, input logic [31:0] wd,
                         output logic v, output logic [31:0] rd, output logic e);
      int n;
      @(negedge clk);
      req_valid = 1'b1; req_write = w; req_size = sz; req_unsigned = u;
      req_addr = a; req_wdata = wd; resp_ready = 1'b1;
      #1;
      n = 0;
      while (req_ready !== 1'b1 && n < 200) begin
         @(negedge clk); #1; n++;
      end
      if (req_ready !== 1'b1) begin
         checks++; errors++;
         $display("FAIL accept_timeout addr=%h ready=%b required 1", a, req_ready);
      end
      @(posedge clk);
      #1 req_valid = 1'b0;
      @(negedge clk);
      v = resp_valid; rd = resp_rdata; e = resp_err;
   endtask

   task automatic count_init(output int n);
      n = 0;
      #1;
      while (req_ready !== 1'b1 && n < 100) begin
         @(negedge clk); #1; n++;
      end
   endtask

   task automatic test_reset;
      int n;
      logic v, e, xe;
      logic [31:0] rd, xr;
      rst_n = 1'b0; req_valid = 1'b0; resp_ready = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL rst_resp_valid got %b exp 0", resp_valid); end
      checks++; if (resp_rdata !== 32'd0) begin errors++; $display("FAIL rst_resp_rdata got %h exp 0", resp_rdata); end
      checks++; if (resp_err !== 1'b0) begin errors++; $display("FAIL rst_resp_err got %b exp 0", resp_err); end
      rst_n = 1'b1;
      count_init(n);
      checks++; if (n != EXP_INIT) begin errors++; $display("FAIL init_cycles got %0d exp %0d", n, EXP_INIT); end
`ifndef DMEM_INIT_CLEAR_EN
      for (int i = 0; i < int'(DEPTH); i++) begin
         model(1'b1, 2'd2, 1'b0, 32'(4 * i), 32'd0, xr, xe);
         do_req(1'b1, 2'd2, 1'b0, 32'(4 * i), 32'd0, v, rd, e);
      end
`endif
      model(1'b0, 2'd2, 1'b0, 32'h3C, 32'd0, xr, xe);
      do_req(1'b0, 2'd2, 1'b0, 32'h3C, 32'd0, v, rd, e);
      checks++; if (v !== 1'b1 || rd !== 32'd0 || e !== 1'b0)
         begin errors++; $display("FAIL lw_3c got v=%b rd=%h e=%b exp v=1 rd=0 e=0", v, rd, e); end
   endtask

   task automatic test_byte_half;
      logic v, e, xe;
      logic [31:0] rd, xr;
      logic [2:0]  sz [5];
      logic        un [5];
      logic [31:0] ad [5];
      logic [31:0] ex [5];
      sz = '{2'd2, 2'd0, 2'd0, 2'd1, 2'd1};
      un = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
      ad = '{32'h04, 32'h07, 32'h07, 32'h04, 32'h06};
      ex = '{32'h0, 32'hFFFF_FF80, 32'h0000_0080, 32'h0000_7F01, 32'h0000_80FF};
      for (int i = 0; i < 5; i++) begin
         model(i == 0, sz[i][1:0], un[i], ad[i], 32'h80FF_7F01, xr, xe);
         do_req(i == 0, sz[i][1:0], un[i], ad[i], 32'h80FF_7F01, v, rd, e);
         checks++; if (rd !== ex[i] || rd !== xr || e !== 1'b0)
            begin errors++; $display("FAIL byte_half[%0d] got %h err=%b exp %h err=0", i, rd, e, ex[i]); end
      end
   endtask

   task automatic test_partial_store;
      logic v, e, xe;
      logic [31:0] rd, xr;
      model(1'b1, 2'd2, 1'b0, 32'h08, 32'h1122_3344, xr, xe);
      do_req(1'b1, 2'd2, 1'b0, 32'h08, 32'h1122_3344, v, rd, e);
      checks++; if (rd !== 32'd0 || e !== 1'b0) begin errors++; $display("FAIL sw_resp got %h err=%b exp 0 err=0", rd, e); end
      model(1'b1, 2'd0, 1'b0, 32'h09, 32'h0000_00AA, xr, xe);
      do_req(1'b1, 2'd0, 1'b0, 32'h09, 32'h0000_00AA, v, rd, e);
      model(1'b0, 2'd2, 1'b0, 32'h08, 32'd0, xr, xe);
      do_req(1'b0, 2'd2, 1'b0, 32'h08, 32'd0, v, rd, e);
      checks++; if (rd !== 32'h1122_AA44 || e !== 1'b0)
         begin errors++; $display("FAIL partial_store got %h err=%b exp 1122aa44 err=0", rd, e); end
   endtask

   task automatic test_errors;
      logic v, e, xe;
      logic [31:0] rd, xr;
      logic        wr [6];
      logic [1:0]  sz [6];
      logic [31:0] ad [6];
      wr = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
      sz = '{2'd2, 2'd1, 2'd3, 2'd2, 2'd2, 2'd1};
      ad = '{32'h02, 32'h03, 32'h08, 32'h40, 32'h40, 32'h05};
      for (int i = 0; i < 6; i++) begin
         model(wr[i], sz[i], 1'b0, ad[i], 32'hDEAD_BEEF, xr, xe);
         do_req(wr[i], sz[i], 1'b0, ad[i], 32'hDEAD_BEEF, v, rd, e);
         checks++; if (v !== 1'b1 || e !== 1'b1 || rd !== 32'd0)
            begin errors++; $display("FAIL err_case[%0d] got v=%b e=%b rd=%h exp v=1 e=1 rd=0", i, v, e, rd); end
      end
      model(1'b0, 2'd2, 1'b0, 32'h08, 32'd0, xr, xe);
      do_req(1'b0, 2'd2, 1'b0, 32'h08, 32'd0, v, rd, e);
      checks++; if (rd !== 32'h1122_AA44 || e !== 1'b0)
         begin errors++; $display("FAIL err_no_write_08 got %h exp 1122aa44", rd); end
      model(1'b0, 2'd2, 1'b0, 32'h04, 32'd0, xr, xe);
      do_req(1'b0, 2'd2, 1'b0, 32'h04, 32'd0, v, rd, e);
      checks++; if (rd !== 32'h80FF_7F01 || e !== 1'b0)
         begin errors++; $display("FAIL err_no_write_04 got %h exp 80ff7f01", rd); end
   endtask

   task automatic test_random;
      logic v, e, xe, w, u;
      logic [1:0]  sz;
      logic [31:0] rd, xr, a, wd;
      for (int i = 0; i < 120; i++) begin
         w  = 1'($urandom_range(0, 1));
         u  = 1'($urandom_range(0, 1));
         sz = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
         a  = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 71));
         wd = $urandom;
         model(w, sz, u, a, wd, xr, xe);
         do_req(w, sz, u, a, wd, v, rd, e);
         checks++; if (v !== 1'b1 || rd !== xr || e !== xe)
            begin errors++; $display("FAIL random[%0d] w=%b sz=%0d a=%h got v=%b rd=%h e=%b exp rd=%h e=%b",
                                     i, w, sz, a, v, rd, e, xr, xe); end
      end
   endtask

   task automatic test_back_to_back;
      logic v, e, xe;
      logic [31:0] rd, xr, held;
      logic        bw [8];
      logic [31:0] ba [8];
      logic [31:0] bd [8];
      logic [31:0] bx [8];
      int acc;
      int bad;
      model(1'b1, 2'd2, 1'b0, 32'h10, 32'hCAFE_F00D, xr, xe);
      do_req(1'b1, 2'd2, 1'b0, 32'h10, 32'hCAFE_F00D, v, rd, e);
      @(negedge clk);
      req_valid = 1'b1; req_write = 1'b0; req_size = 2'd2; req_unsigned = 1'b0;
      req_addr = 32'h10; resp_ready = 1'b0;
      @(posedge clk);
      #1 req_write = 1'b1; req_addr = 32'h14; req_wdata = $urandom;
      bad = 0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if (resp_valid !== 1'b1 || resp_rdata !== 32'hCAFE_F00D || resp_err !== 1'b0 || req_ready !== 1'b0) bad++;
      end
      checks++; if (bad != 0) begin errors++;
         $display("FAIL stall_stable bad_cycles=%0d rv=%b rd=%h rr=%b exp 0 bad cycles", bad, resp_valid, resp_rdata, req_ready); end
      for (int k = 0; k < 8; k++) begin
         bw[k] = 1'($urandom_range(0, 1));
         ba[k] = 32'h20 + 32'(4 * $urandom_range(0, 3));
         bd[k] = $urandom;
         model(bw[k], 2'd2, 1'b0, ba[k], bd[k], bx[k], xe);
      end
      acc = 0; bad = 0;
      for (int k = 0; k < 8; k++) begin
         if (k > 0) begin
            @(negedge clk);
            if (resp_valid !== 1'b1 || resp_rdata !== bx[k-1] || resp_err !== 1'b0) begin
               bad++;
               $display("FAIL b2b_resp[%0d] got v=%b rd=%h exp v=1 rd=%h", k - 1, resp_valid, resp_rdata, bx[k-1]);
            end
         end
         req_valid = 1'b1; req_write = bw[k]; req_size = 2'd2; req_addr = ba[k]; req_wdata = bd[k];
         resp_ready = 1'b1;
         #1 if (req_ready === 1'b1) acc++;
         @(posedge clk);
      end
      @(negedge clk);
      if (resp_valid !== 1'b1 || resp_rdata !== bx[7] || resp_err !== 1'b0) begin
         bad++;
         $display("FAIL b2b_resp[7] got v=%b rd=%h exp v=1 rd=%h", resp_valid, resp_rdata, bx[7]);
      end
      req_valid = 1'b0;
      checks++; if (bad != 0) begin errors++; $display("FAIL b2b_data bad=%0d exp 0", bad); end
      checks++; if (acc != 8) begin errors++; $display("FAIL b2b_rate accepted=%0d exp 8 in 8 cycles", acc); end
      held = 32'd0;
      model(1'b0, 2'd2, 1'b0, 32'h14, 32'd0, held, xe);
      do_req(1'b0, 2'd2, 1'b0, 32'h14, 32'd0, v, rd, e);
      checks++; if (rd !== held) begin errors++; $display("FAIL stall_ignored_store got %h exp %h", rd, held); end
   endtask

   task automatic test_midop_reset;
      int n;
      logic v, e, xe;
      logic [31:0] rd, xr;
      @(negedge clk);
      req_valid = 1'b1; req_write = 1'b0; req_size = 2'd2; req_addr = 32'h08; resp_ready = 1'b0;
      @(posedge clk);
      #1 req_valid = 1'b0;
      @(negedge clk);
      checks++; if (resp_valid !== 1'b1) begin errors++; $display("FAIL midop_pending got %b exp 1", resp_valid); end
      #2 rst_n = 1'b0;
      #1;
      checks++; if (resp_valid !== 1'b0 || resp_rdata !== 32'd0)
         begin errors++; $display("FAIL midop_async got v=%b rd=%h exp v=0 rd=0", resp_valid, resp_rdata); end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      count_init(n);
      checks++; if (n != EXP_INIT) begin errors++; $display("FAIL midop_init_cycles got %0d exp %0d", n, EXP_INIT); end
`ifdef DMEM_INIT_CLEAR_EN
      for (int i = 0; i < int'(NBYTES); i++) m_byte[i] = 8'd0;
`endif
      for (int i = 0; i < 4; i++) begin
         model(1'b0, 2'd2, 1'b0, 32'(16 * i + 8), 32'd0, xr, xe);
         do_req(1'b0, 2'd2, 1'b0, 32'(16 * i + 8), 32'd0, v, rd, e);
         checks++; if (v !== 1'b1 || rd !== xr || e !== 1'b0)
            begin errors++; $display("FAIL midop_read[%0d] got %h exp %h", i, rd, xr); end
      end
   endtask

   initial begin
      for (int i = 0; i < int'(NBYTES); i++) m_byte[i] = 8'd0;
      rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_size = 2'd0;
      req_unsigned = 1'b0; req_addr = '0; req_wdata = '0; resp_ready = 1'b0;
      test_reset;
      test_byte_half;
      test_partial_store;
      test_errors;
      test_random;
      test_back_to_back;
      test_midop_reset;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout reached exp finish before limit");
      $fatal(1);
   end

endmodule
